mem_responder: RTL

//  Memory-side responder for the core's multicycle memory interface (mem_read/mem_write/
//  mem_byte_enable/mem_resp). Word-organised on-chip RAM with programmable response latency.

---
 rtl/mem_responder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Word-organised on-chip RAM answering the multicycle memory handshake after a fixed,
// programmable latency; flags out-of-range and read+write requests via mem_error_o.
module mem_responder #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [3:0]  mem_byte_enable_i,
    input  logic [31:0] mem_address_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_resp_o,
    output logic [31:0] mem_rdata_o,
    output logic        mem_error_o
);

    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    wr_q, wr_d;
    logic                    oor_q, oor_d;
    logic                    err_q, err_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    error_q, error_d;
    logic [31:0]             mem_q [Words];

    logic                    req;
    logic                    in_oor;
    logic                    enter_resp;
    logic                    commit;

    assign req    = mem_read_i | mem_write_i;
    assign in_oor = (mem_address_i >> (DEPTH_LOG2 + 2)) != 32'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        oor_d      = oor_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    idx_d   = mem_address_i[DEPTH_LOG2+1:2];
                    wdata_d = mem_wdata_i;
                    be_d    = mem_byte_enable_i;
                    wr_d    = mem_write_i;
                    oor_d   = in_oor;
                    err_d   = in_oor | (mem_read_i & mem_write_i);
                    cnt_d   = CntW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                // Initiator dropping the request mid-flight cancels the transaction.
                if (!req) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(1)) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read data is captured on entry to RESP so it is valid exactly in the resp cycle.
    always_comb begin
        rdata_d = rdata_q;
        error_d = 1'b0;
        if (enter_resp) begin
            rdata_d = err_d ? 32'd0 : mem_q[idx_d];
            error_d = err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign commit = (state_q == StResp) & wr_q & ~oor_q & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_resp_o  = (state_q == StResp);
    assign mem_rdata_o = rdata_q;
    assign mem_error_o = error_q;

endmodule
